chip8_keypad: RTL and testbench
===============================

Name: chip8_keypad

Overview:
- Converts MiSTer `ps2_key` events into the 16-bit CHIP-8 hex keypad matrix that feeds the CPU `keyMatrix` input.
- Provides a selectable keymap and filters typematic repeats.
- Queues press/release events in a parametrised FIFO, which FX0A-style wait-for-key logic drains through a valid/pop handshake.
- Sits between the HPS keyboard input and `cpu` in the `chip8` top level. It replaces the undriven `keyboard_matrix` register.

Parameters:
- FIFO_DEPTH, 4: event queue entries; power of two, ≥2.
- FIFO_AW, $clog2(FIFO_DEPTH): pointer width; derived, not overridden.
- REPEAT_FILTER, 1: 1 = push an event only when a matrix bit changes; 0 = push every mapped make/break.

Ports:
- clk  in  1  system clock (cpu_clk domain).
- res_n  in  1  reset, synchronous, active-low.
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 scancode.
- keymap  in  2  0 = COSMAC (1234/QWER/ASDF/ZXCV), 1 = numeric keypad, 2 = both merged, 3 = treated as 0.
- clear  in  1  one-cycle pulse: release all keys, flush FIFO, clear overflow.
- key_matrix  out  16  bit k = hex key k held.
- any_down  out  1  OR of key_matrix.
- ev_valid  out  1  FIFO non-empty.
- ev_data  out  5  {pressed, key[3:0]}; head entry, first-word fall-through.
- ev_pop  in  1  consume head when ev_valid.
- overflow  out  1  sticky: an event was dropped on a full FIFO.

Behaviour:
- Reset (res_n=0 at posedge): key_matrix=0, any_down=0, FIFO empty, ev_valid=0, ev_data=0, overflow=0. The toggle history register loads ps2_key[10] so that no spurious event fires. The mode register loads keymap.
- New event: ps2_key[10] ≠ stored toggle at posedge N.
  - Decode, matrix update and FIFO push all occur at edge N.
  - key_matrix and ev_valid are visible from cycle N+1 (1-cycle latency).
  - The toggle history updates every cycle.
- Decode: the lookup is on {ext, code}. An unmapped code is ignored: no matrix change, no push.
- COSMAC map, ext=0:
  - 16→1, 1E→2, 26→3, 25→C
  - 15→4, 1D→5, 24→6, 2D→D
  - 1C→7, 1B→8, 23→9, 2B→E
  - 1A→A, 22→0, 21→B, 2A→F
- Numpad map:
  - ext=0: 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9, 7C→B, 7B→C, 79→D, 71→F.
  - ext=1: 4A→A, 5A→E.
- Merged mode: a code matches if it is in either map.
- Matrix: key_matrix[k] <= pressed.
- FIFO push condition:
  - REPEAT_FILTER=1: push {pressed,k} only if key_matrix[k] ≠ pressed before the update. Make-repeats are therefore dropped.
  - REPEAT_FILTER=0: push on every mapped event.
- FIFO operation:
  - Pop is accepted only when ev_valid=1; ev_pop while empty is ignored.
  - Push and pop on the same edge: both occur and count is unchanged. This also holds when full, because the pop frees the slot.
  - Push when full with no pop: the event is dropped and overflow is set. The matrix still updates.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_data holds its last value when empty and is don't-care to the consumer.
- clear: at that edge, key_matrix=0, FIFO empty, overflow=0.
  - clear has priority over a simultaneous key event (event discarded) and over ev_pop.
- keymap change: when registered mode ≠ keymap, key_matrix clears and the mode register updates, with no events pushed. A key event in the same cycle is decoded with the new map after the clear.
- Reset asserted mid-operation returns everything to reset values on the next edge regardless of other inputs.

Decomposition:
- Package chip8_keypad_pkg:
  - keymap enum (KM_COSMAC, KM_NUMPAD, KM_BOTH).
  - EV_W=5.
  - Scancode constants.
  - Function map_key({ext,code}, mode) returning {hit, key[3:0]}.
- Sub-module keypad_fifo: synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, res_n, clr, push, din, pop, dout, empty, full.

Test Plan:
- After reset, toggle ps2_key with {pressed=1, ext=0, 0x1D} in mode 0 → key_matrix=0x0020 next cycle, ev_valid=1, ev_data=5'h15, any_down=1.
- Send 0x1D make three times (typematic), then break, with REPEAT_FILTER=1 → exactly 2 FIFO entries (5'h15, then 5'h05); key_matrix ends at 0.
- Mode 1: ext=1 0x5A make → key_matrix[E]=1. Then ext=0 0x5A → ignored. Switch to mode 0 → key_matrix=0 and no new events.
- With FIFO_DEPTH=4, send 5 distinct makes without popping → 4 entries, overflow=1. Pop 4 times → ev_data sequence matches the first 4 makes, then ev_valid=0.
- With the FIFO full, issue a new make plus ev_pop on the same cycle → count stays 4, the head advances and overflow stays 0. ev_pop while empty → no change.
- A key event coincident with clear → key_matrix=0, FIFO empty, overflow=0; the event is discarded. Asserting res_n=0 mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/chip8_keypad_pkg.sv
// chip8_keypad_pkg: shared types, constants and the scancode decoder for the CHIP-8 keypad.
//   keymap_e  - keymap selection (3 decodes as COSMAC)
//   EV_W      - FIFO event width {pressed, key[3:0]}
//   map_key   - {ext, code} + mode -> {hit, key[3:0]}
package chip8_keypad_pkg;

    typedef enum logic [1:0] {
        KM_COSMAC = 2'd0,
        KM_NUMPAD = 2'd1,
        KM_BOTH   = 2'd2
    } keymap_e;

    localparam int unsigned EV_W = 5;

    // PS/2 set-2 make codes, COSMAC layout (1234/QWER/ASDF/ZXCV)
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_Z = 8'h1A;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_V = 8'h2A;

    // Numeric keypad; SLASH and ENTER arrive with the extended prefix
    localparam logic [7:0] SC_KP0     = 8'h70;
    localparam logic [7:0] SC_KP1     = 8'h69;
    localparam logic [7:0] SC_KP2     = 8'h72;
    localparam logic [7:0] SC_KP3     = 8'h7A;
    localparam logic [7:0] SC_KP4     = 8'h6B;
    localparam logic [7:0] SC_KP5     = 8'h73;
    localparam logic [7:0] SC_KP6     = 8'h74;
    localparam logic [7:0] SC_KP7     = 8'h6C;
    localparam logic [7:0] SC_KP8     = 8'h75;
    localparam logic [7:0] SC_KP9     = 8'h7D;
    localparam logic [7:0] SC_KP_STAR = 8'h7C;
    localparam logic [7:0] SC_KP_MIN  = 8'h7B;
    localparam logic [7:0] SC_KP_PLUS = 8'h79;
    localparam logic [7:0] SC_KP_DOT  = 8'h71;
    localparam logic [7:0] SC_KP_DIV  = 8'h4A;
    localparam logic [7:0] SC_KP_ENT  = 8'h5A;

    function automatic logic [4:0] map_cosmac(input logic [8:0] sc);
        case (sc)
            {1'b0, SC_1}: return 5'h11;
            {1'b0, SC_2}: return 5'h12;
            {1'b0, SC_3}: return 5'h13;
            {1'b0, SC_4}: return 5'h1C;
            {1'b0, SC_Q}: return 5'h14;
            {1'b0, SC_W}: return 5'h15;
            {1'b0, SC_E}: return 5'h16;
            {1'b0, SC_R}: return 5'h1D;
            {1'b0, SC_A}: return 5'h17;
            {1'b0, SC_S}: return 5'h18;
            {1'b0, SC_D}: return 5'h19;
            {1'b0, SC_F}: return 5'h1E;
            {1'b0, SC_Z}: return 5'h1A;
            {1'b0, SC_X}: return 5'h10;
            {1'b0, SC_C}: return 5'h1B;
            {1'b0, SC_V}: return 5'h1F;
            default:      return 5'h00;
        endcase
    endfunction

    function automatic logic [4:0] map_numpad(input logic [8:0] sc);
        case (sc)
            {1'b0, SC_KP0}:     return 5'h10;
            {1'b0, SC_KP1}:     return 5'h11;
            {1'b0, SC_KP2}:     return 5'h12;
            {1'b0, SC_KP3}:     return 5'h13;
            {1'b0, SC_KP4}:     return 5'h14;
            {1'b0, SC_KP5}:     return 5'h15;
            {1'b0, SC_KP6}:     return 5'h16;
            {1'b0, SC_KP7}:     return 5'h17;
            {1'b0, SC_KP8}:     return 5'h18;
            {1'b0, SC_KP9}:     return 5'h19;
            {1'b0, SC_KP_STAR}: return 5'h1B;
            {1'b0, SC_KP_MIN}:  return 5'h1C;
            {1'b0, SC_KP_PLUS}: return 5'h1D;
            {1'b0, SC_KP_DOT}:  return 5'h1F;
            {1'b1, SC_KP_DIV}:  return 5'h1A;
            {1'b1, SC_KP_ENT}:  return 5'h1E;
            default:            return 5'h00;
        endcase
    endfunction

    // Returns {hit, key}. The two maps share no codes, so merging is a simple fallback.
    function automatic logic [4:0] map_key(input logic [8:0] sc, input logic [1:0] mode);
        logic [4:0] cos;
        logic [4:0] num;
        cos = map_cosmac(sc);
        num = map_numpad(sc);
        case (mode)
            KM_NUMPAD: return num;
            KM_BOTH:   return cos[4] ? cos : num;
            default:   return cos;
        endcase
    endfunction

endpackage

// File: rtl/chip8_keypad_fifo.sv
// keypad_fifo: synchronous first-word-fall-through FIFO.
//   clk, res_n - clock, synchronous active-low reset
//   clr        - flush (pointers and count to zero)
//   push, din  - write; ignored when full unless a pop is accepted on the same edge
//   pop        - consume head; ignored when empty
//   dout       - head entry (valid while !empty)
//   empty/full - status
module keypad_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        do_push = push & (~full | do_pop);
        dout    = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/chip8_keypad.sv
// chip8_keypad: PS/2 key events -> CHIP-8 16-key matrix plus a press/release event FIFO.
//   clk, res_n  - cpu clock, synchronous active-low reset
//   ps2_key     - [10] toggle strobe, [9] pressed, [8] extended, [7:0] set-2 code
//   keymap      - 0 COSMAC, 1 numpad, 2 both, 3 as 0
//   clear       - release all keys, flush FIFO, clear overflow (beats key event and pop)
//   key_matrix  - bit k = hex key k held; any_down = OR of it
//   ev_valid/ev_data/ev_pop - FWFT event queue, ev_data = {pressed, key}
//   overflow    - sticky, set when an event is dropped on a full FIFO
module chip8_keypad
    import chip8_keypad_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FIFO_AW       = $clog2(FIFO_DEPTH),
    parameter bit          REPEAT_FILTER = 1'b1
) (
    input  logic            clk,
    input  logic            res_n,
    input  logic [10:0]     ps2_key,
    input  logic [1:0]      keymap,
    input  logic            clear,
    output logic [15:0]     key_matrix,
    output logic            any_down,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_data,
    input  logic            ev_pop,
    output logic            overflow
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
            || FIFO_AW != $clog2(FIFO_DEPTH)) begin : g_bad_depth
        $error("chip8_keypad: FIFO_DEPTH must be a power of two >= 2");
    end

    logic            toggle_q;
    logic [1:0]      mode_q;
    logic [15:0]     matrix_q;
    logic [15:0]     matrix_d;
    logic            overflow_q;
    logic            overflow_d;

    logic            ev_fire;
    logic            mode_change;
    logic [4:0]      hit_key;
    logic [3:0]      key_idx;
    logic            pressed;
    logic            changed;
    logic            push_req;
    logic            pop_req;
    logic            fifo_empty;
    logic            fifo_full;

    always_comb begin
        ev_fire     = ps2_key[10] ^ toggle_q;
        mode_change = (keymap != mode_q);
        // Decode with the incoming keymap: equal to mode_q unless it is changing this
        // cycle, in which case the event belongs to the new map.
        hit_key     = map_key(ps2_key[8:0], keymap);
        key_idx     = hit_key[3:0];
        pressed     = ps2_key[9];

        // A keymap change releases everything before the event is applied.
        matrix_d    = mode_change ? 16'h0000 : matrix_q;
        changed     = (matrix_d[key_idx] != pressed);
        push_req    = 1'b0;
        if (ev_fire && hit_key[4]) begin
            matrix_d[key_idx] = pressed;
            push_req          = REPEAT_FILTER ? changed : 1'b1;
        end
        if (clear) begin
            matrix_d = 16'h0000;
            push_req = 1'b0;
        end

        pop_req    = ev_pop & ~fifo_empty & ~clear;
        overflow_d = clear ? 1'b0 : (overflow_q | (push_req & fifo_full & ~pop_req));
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            // Track the strobe through reset so its level is not mistaken for an event.
            toggle_q   <= ps2_key[10];
            mode_q     <= keymap;
            matrix_q   <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            toggle_q   <= ps2_key[10];
            mode_q     <= keymap;
            matrix_q   <= matrix_d;
            overflow_q <= overflow_d;
        end
    end

    keypad_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res_n (res_n),
        .clr   (clear),
        .push  (push_req),
        .din   ({pressed, key_idx}),
        .pop   (pop_req),
        .dout  (ev_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign key_matrix = matrix_q;
    assign any_down   = |matrix_q;
    assign ev_valid   = ~fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_chip8_keypad.sv
module tb_chip8_keypad;

    localparam int unsigned DEPTH  = 4;
    localparam bit          FILTER = 1'b1;

    logic        clk;
    logic        res_n;
    logic [10:0] ps2_key;
    logic [1:0]  keymap;
    logic        clear;
    logic [15:0] key_matrix;
    logic        any_down;
    logic        ev_valid;
    logic [4:0]  ev_data;
    logic        ev_pop;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    chip8_keypad #(
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_FILTER (FILTER)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .ps2_key    (ps2_key),
        .keymap     (keymap),
        .clear      (clear),
        .key_matrix (key_matrix),
        .any_down   (any_down),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_pop     (ev_pop),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tables indexed by hex key, holding {ext, code}.
    logic [8:0]  cos_tab [16];
    logic [8:0]  num_tab [16];
    logic [15:0] m_matrix;
    logic [4:0]  m_q [$];
    logic        m_ovf;
    logic        m_tog;
    logic [1:0]  m_mode;
    logic        tog;

    task automatic init_tables();
        cos_tab[0]  = 9'h022; cos_tab[1]  = 9'h016; cos_tab[2]  = 9'h01E; cos_tab[3]  = 9'h026;
        cos_tab[4]  = 9'h015; cos_tab[5]  = 9'h01D; cos_tab[6]  = 9'h024; cos_tab[7]  = 9'h01C;
        cos_tab[8]  = 9'h01B; cos_tab[9]  = 9'h023; cos_tab[10] = 9'h01A; cos_tab[11] = 9'h021;
        cos_tab[12] = 9'h025; cos_tab[13] = 9'h02D; cos_tab[14] = 9'h02B; cos_tab[15] = 9'h02A;
        num_tab[0]  = 9'h070; num_tab[1]  = 9'h069; num_tab[2]  = 9'h072; num_tab[3]  = 9'h07A;
        num_tab[4]  = 9'h06B; num_tab[5]  = 9'h073; num_tab[6]  = 9'h074; num_tab[7]  = 9'h06C;
        num_tab[8]  = 9'h075; num_tab[9]  = 9'h07D; num_tab[10] = 9'h14A; num_tab[11] = 9'h07C;
        num_tab[12] = 9'h07B; num_tab[13] = 9'h079; num_tab[14] = 9'h15A; num_tab[15] = 9'h071;
    endtask

    function automatic logic [4:0] ref_lookup(input logic [8:0] sc, input logic [1:0] km);
        int eff;
        eff = (km == 2'd3) ? 0 : int'(km);
        for (int k = 0; k < 16; k++) begin
            if (eff != 1 && cos_tab[k] == sc) return {1'b1, 4'(k)};
            if (eff != 0 && num_tab[k] == sc) return {1'b1, 4'(k)};
        end
        return 5'h00;
    endfunction

    task automatic model_step();
        logic       ev;
        logic [4:0] lk;
        logic       was;
        if (!res_n) begin
            m_matrix = '0; m_q.delete(); m_ovf = 1'b0;
            m_tog = ps2_key[10]; m_mode = keymap;
            return;
        end
        ev    = (ps2_key[10] != m_tog);
        m_tog = ps2_key[10];
        if (clear) begin
            m_matrix = '0; m_q.delete(); m_ovf = 1'b0; m_mode = keymap;
            return;
        end
        if (m_mode != keymap) begin
            m_matrix = '0;
            m_mode   = keymap;
        end
        if (ev_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (ev) begin
            lk = ref_lookup(ps2_key[8:0], keymap);
            if (lk[4]) begin
                was = m_matrix[lk[3:0]];
                m_matrix[lk[3:0]] = ps2_key[9];
                if (!FILTER || was != ps2_key[9]) begin
                    if (m_q.size() < DEPTH) m_q.push_back({ps2_key[9], lk[3:0]});
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model, then waits past the edge.
    task automatic cycle(input bit fire, input logic p, input logic e, input logic [7:0] c,
                         input logic clr, input logic pop);
        if (fire) tog = ~tog;
        ps2_key = {tog, p, e, c};
        clear   = clr;
        ev_pop  = pop;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h16, 1'b0, 1'b1);
        checks++; if (key_matrix !== 16'h0000) begin errors++;
            $display("FAIL reset_matrix: got %h want 0000", key_matrix); end
        checks++; if (ev_valid !== 1'b0 || any_down !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL reset_flags: valid=%b any=%b ovf=%b want 0 0 0", ev_valid, any_down, overflow); end
        checks++; if (ev_data !== 5'h00) begin errors++;
            $display("FAIL reset_data: got %h want 00", ev_data); end
        res_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (ev_valid !== 1'b0 || key_matrix !== 16'h0000) begin errors++;
            $display("FAIL reset_no_spurious: valid=%b matrix=%h want 0 0000", ev_valid, key_matrix); end
    endtask

    task automatic test_basic();
        cycle(1'b1, 1'b1, 1'b0, 8'h1D, 1'b0, 1'b0);
        checks++; if (key_matrix !== 16'h0020) begin errors++;
            $display("FAIL basic_matrix: got %h want 0020", key_matrix); end
        checks++; if (ev_valid !== 1'b1 || any_down !== 1'b1) begin errors++;
            $display("FAIL basic_flags: valid=%b any=%b want 1 1", ev_valid, any_down); end
        checks++; if (ev_data !== 5'h15) begin errors++;
            $display("FAIL basic_data: got %h want 15", ev_data); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_typematic();
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 8'h1D, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h1D, 1'b0, 1'b0);
        checks++; if (key_matrix !== 16'h0000 || ev_data !== 5'h15) begin errors++;
            $display("FAIL typ_first: matrix=%h data=%h want 0000 15", key_matrix, ev_data); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (ev_valid !== 1'b1 || ev_data !== 5'h05) begin errors++;
            $display("FAIL typ_second: valid=%b data=%h want 1 05", ev_valid, ev_data); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (ev_valid !== 1'b0) begin errors++;
            $display("FAIL typ_count: valid=%b want 0 after two pops", ev_valid); end
    endtask

    task automatic test_numpad();
        keymap = 2'd1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (key_matrix !== 16'h4000 || ev_data !== 5'h1E) begin errors++;
            $display("FAIL num_enter: matrix=%h data=%h want 4000 1e", key_matrix, ev_data); end
        cycle(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
        checks++; if (key_matrix !== 16'h4000 || ev_valid !== 1'b0) begin errors++;
            $display("FAIL num_unmapped: matrix=%h valid=%b want 4000 0", key_matrix, ev_valid); end
        keymap = 2'd0;
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (key_matrix !== 16'h0000 || ev_valid !== 1'b0) begin errors++;
            $display("FAIL num_modechg: matrix=%h valid=%b want 0000 0", key_matrix, ev_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        logic [4:0] exp [4];
        codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h15;
        exp[0] = 5'h11; exp[1] = 5'h12; exp[2] = 5'h13; exp[3] = 5'h1C;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, codes[i], 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1 || key_matrix !== 16'h101E) begin errors++;
            $display("FAIL ovf_set: ovf=%b matrix=%h want 1 101e", overflow, key_matrix); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_valid !== 1'b1 || ev_data !== exp[i]) begin errors++;
                $display("FAIL ovf_pop%0d: valid=%b data=%h want 1 %h", i, ev_valid, ev_data, exp[i]); end
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        checks++; if (ev_valid !== 1'b0 || overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_drained: valid=%b ovf=%b want 0 1", ev_valid, overflow); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0 || key_matrix !== 16'h0000) begin errors++;
            $display("FAIL ovf_clear: ovf=%b matrix=%h want 0 0000", overflow, key_matrix); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] codes [4];
        logic [4:0] exp [4];
        codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25;
        exp[0] = 5'h12; exp[1] = 5'h13; exp[2] = 5'h1C; exp[3] = 5'h14;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, codes[i], 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0 || ev_data !== 5'h12) begin errors++;
            $display("FAIL full_pushpop: ovf=%b data=%h want 0 12", overflow, ev_data); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ev_valid !== 1'b1 || ev_data !== exp[i]) begin errors++;
                $display("FAIL full_seq%0d: valid=%b data=%h want 1 %h", i, ev_valid, ev_data, exp[i]); end
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (ev_valid !== 1'b0 || key_matrix !== 16'h101E || overflow !== 1'b0) begin errors++;
            $display("FAIL pop_empty: valid=%b matrix=%h ovf=%b want 0 101e 0",
                     ev_valid, key_matrix, overflow); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, cos_tab[i + 5][7:0], 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h2A, 1'b1, 1'b1);
        checks++; if (key_matrix !== 16'h0000 || ev_valid !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL clear_event: matrix=%h valid=%b ovf=%b want 0000 0 0",
                     key_matrix, ev_valid, overflow); end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (key_matrix !== 16'h0000 || ev_valid !== 1'b0) begin errors++;
            $display("FAIL clear_discard: matrix=%h valid=%b want 0000 0", key_matrix, ev_valid); end
    endtask

    task automatic test_random();
        logic [8:0] sc;
        logic [4:0] head;
        int         r;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0) keymap = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 4)      sc = cos_tab[$urandom_range(0, 15)];
            else if (r < 7) sc = num_tab[$urandom_range(0, 15)];
            else            sc = 9'($urandom);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sc[8], sc[7:0],
                  1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) == 0));
            head = (m_q.size() > 0) ? m_q[0] : 5'h00;
            checks++; if (key_matrix !== m_matrix || any_down !== (|m_matrix)) begin errors++;
                $display("FAIL rnd_matrix @%0d: got %h/%b want %h", n, key_matrix, any_down, m_matrix); end
            checks++; if (ev_valid !== (m_q.size() > 0) || overflow !== m_ovf) begin errors++;
                $display("FAIL rnd_fifo @%0d: valid=%b ovf=%b want %b %b", n, ev_valid, overflow,
                         (m_q.size() > 0), m_ovf); end
            if (m_q.size() > 0) begin
                checks++; if (ev_data !== head) begin errors++;
                    $display("FAIL rnd_data @%0d: got %h want %h", n, ev_data, head); end
            end
        end
        keymap = 2'd0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, cos_tab[i][7:0], 1'b0, 1'b0);
        res_n = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1);
        checks++; if (key_matrix !== 16'h0000 || any_down !== 1'b0 || ev_valid !== 1'b0
                      || overflow !== 1'b0 || ev_data !== 5'h00) begin errors++;
            $display("FAIL reset_mid: matrix=%h any=%b valid=%b ovf=%b data=%h want all 0",
                     key_matrix, any_down, ev_valid, overflow, ev_data); end
        res_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b0);
        checks++; if (key_matrix !== 16'h0000 || ev_valid !== 1'b0) begin errors++;
            $display("FAIL reset_mid_after: matrix=%h valid=%b want 0000 0", key_matrix, ev_valid); end
    endtask

    initial begin
        init_tables();
        res_n   = 1'b0;
        tog     = 1'b0;
        ps2_key = '0;
        keymap  = 2'd0;
        clear   = 1'b0;
        ev_pop  = 1'b0;
        test_reset();
        test_basic();
        test_typematic();
        test_numpad();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
